iob_wishbone_slice: RTL
=======================

# iob_wishbone_slice

Registered Wishbone pipeline stage with a bus-timeout watchdog. It sits directly downstream of the IOb-to-Wishbone bridge and in front of the Ethernet MAC register slave. It breaks the combinational path from the bridge's request outputs to the slave. It also returns a Wishbone error to the bridge when the slave never answers, so a stalled slave cannot hang the IOb master.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- TIMEOUT_CYCLES, 255, maximum downstream stb-high cycles before timeout (>= 1)

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous reset, active-low
- s_addr_i  in  ADDR_W  upstream address
- s_select_i  in  DATA_W/8  upstream byte select
- s_we_i  in  1  upstream write enable
- s_cyc_i  in  1  upstream cycle
- s_stb_i  in  1  upstream strobe
- s_data_i  in  DATA_W  upstream write data
- s_ack_o  out  1  upstream acknowledge
- s_error_o  out  1  upstream error
- s_data_o  out  DATA_W  upstream read data
- m_addr_o  out  ADDR_W  downstream address
- m_select_o  out  DATA_W/8  downstream byte select
- m_we_o  out  1  downstream write enable
- m_cyc_o  out  1  downstream cycle
- m_stb_o  out  1  downstream strobe
- m_data_o  out  DATA_W  downstream write data
- m_ack_i  in  1  downstream acknowledge
- m_error_i  in  1  downstream error
- m_data_i  in  DATA_W  downstream read data
- timeout_o  out  1  one-cycle pulse when a transaction times out

## Operation
- FSM states: IDLE, REQ, RESP. All outputs are registered.
- IDLE:
  - When s_cyc_i & s_stb_i: capture addr/select/we/data into m_* registers, clear the timeout counter, and go to REQ.
  - m_cyc_o and m_stb_o rise on the next cycle.
- REQ:
  - m_cyc_o = m_stb_o = 1; the counter increments each cycle.
  - m_error_i = 1: set s_error_o, drop m_cyc_o/m_stb_o, go to RESP.
  - Else m_ack_i = 1: capture m_data_i into s_data_o, set s_ack_o, drop m_cyc_o/m_stb_o, go to RESP.
  - Else timeout (counter == TIMEOUT_CYCLES-1): set s_error_o and timeout_o, drop m_cyc_o/m_stb_o, go to RESP.
  - Else s_cyc_i = 0 (upstream abort): drop m_cyc_o/m_stb_o, return to IDLE, no response.
- RESP:
  - s_ack_o or s_error_o is high for exactly this one cycle; s_stb_i is ignored.
  - Next state is IDLE; s_ack_o, s_error_o and timeout_o clear.
- Priority for simultaneous events: error > ack > timeout > abort.
- s_data_o holds its last captured value until the next acked read. It is not updated on error or timeout.
- Writes also update s_data_o from m_data_i on ack; upstream ignores it.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.

## Timing
- Reset (arst_i low, asynchronous): state IDLE, counter 0, every output 0, including s_data_o, m_addr_o and m_data_o.
- Reset asserted mid-transaction:
  - m_cyc_o/m_stb_o drop immediately, with no response upstream.
  - After release, the block waits in IDLE for a fresh s_stb_i.
- Latency: request seen at cycle N; m_stb_o high from N+1; slave acks at N+1+k; s_ack_o at N+2+k. The minimum round trip is 2 cycles.
- Timeout: m_stb_o is high for exactly TIMEOUT_CYCLES cycles; s_error_o and timeout_o are high on the following cycle.
- The upstream must keep s_cyc_i/s_stb_i and the request fields stable until s_ack_o/s_error_o. The request fields are sampled only in IDLE.
- Back-to-back: a new request may be accepted on the cycle after RESP, giving one transaction per 3 cycles at best.

## Configuration
- IOB_WB_SLICE_TIMEOUT_EN defined: the timeout counter and timeout path are implemented as above.
- Not defined:
  - No counter is built and REQ waits indefinitely for ack or error.
  - timeout_o is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Read at address 0x40 with slave ack on its first stb cycle, m_data_i = 0xDEADBEEF -> m_stb_o high 1 cycle, s_ack_o pulses at N+2, s_data_o = 0xDEADBEEF.
- Write at 0x44, s_select_i = 0x3, data 0x1234, slave inserts 3 wait states -> m_select_o = 0x3, m_we_o = 1, m_stb_o high 4 cycles, s_ack_o pulses at N+5.
- Slave asserts m_error_i and m_ack_i in the same cycle -> s_error_o = 1, s_ack_o = 0, s_data_o unchanged.
- Macro defined, TIMEOUT_CYCLES = 16, slave silent -> m_stb_o high 16 cycles; s_error_o and timeout_o pulse together 1 cycle; returns to IDLE.
- Ack on the same cycle the counter hits TIMEOUT_CYCLES-1 -> s_ack_o = 1, timeout_o = 0.
- arst_i pulsed low while in REQ -> m_cyc_o/m_stb_o go low asynchronously, no s_ack_o/s_error_o; a subsequent read completes normally.

Source files
------------

// File: rtl/iob_wishbone_slice.sv
// Registered Wishbone pipeline stage with a bus-timeout watchdog.
// Define IOB_WB_SLICE_TIMEOUT_EN to build the timeout counter; otherwise REQ waits forever.
module iob_wishbone_slice #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic [ADDR_W-1:0]   s_addr_i,
   input  logic [DATA_W/8-1:0] s_select_i,
   input  logic                s_we_i,
   input  logic                s_cyc_i,
   input  logic                s_stb_i,
   input  logic [DATA_W-1:0]   s_data_i,
   output logic                s_ack_o,
   output logic                s_error_o,
   output logic [DATA_W-1:0]   s_data_o,
   output logic [ADDR_W-1:0]   m_addr_o,
   output logic [DATA_W/8-1:0] m_select_o,
   output logic                m_we_o,
   output logic                m_cyc_o,
   output logic                m_stb_o,
   output logic [DATA_W-1:0]   m_data_o,
   input  logic                m_ack_i,
   input  logic                m_error_i,
   input  logic [DATA_W-1:0]   m_data_i,
   output logic                timeout_o
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W/8-1:0] sel_q, sel_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                req_q, req_d;  // drives both m_cyc_o and m_stb_o
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic                timeout_hit;

`ifdef IOB_WB_SLICE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      tmo_d = 1'b0;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (state_q == StReq) begin
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         tmo_d = ~m_error_i & ~m_ack_i & timeout_hit;
      end
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign timeout_o = tmo_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q <= StIdle;
         addr_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         req_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (s_cyc_i && s_stb_i) state_d = StReq;
         StReq: begin
            if (m_error_i || m_ack_i || timeout_hit) state_d = StResp;
            else if (!s_cyc_i)                       state_d = StIdle;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Error outranks ack, ack outranks timeout; read data is only taken on a clean ack.
   always_comb begin
      addr_d  = addr_q;
      sel_d   = sel_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      req_d   = (state_d == StReq);
      if (state_q == StIdle && s_cyc_i && s_stb_i) begin
         addr_d  = s_addr_i;
         sel_d   = s_select_i;
         we_d    = s_we_i;
         wdata_d = s_data_i;
      end
      if (state_q == StReq) begin
         err_d = m_error_i | (~m_ack_i & timeout_hit);
         ack_d = ~m_error_i & m_ack_i;
         if (~m_error_i & m_ack_i) rdata_d = m_data_i;
      end
   end

   assign s_ack_o    = ack_q;
   assign s_error_o  = err_q;
   assign s_data_o   = rdata_q;
   assign m_addr_o   = addr_q;
   assign m_select_o = sel_q;
   assign m_we_o     = we_q;
   assign m_cyc_o    = req_q;
   assign m_stb_o    = req_q;
   assign m_data_o   = wdata_q;

endmodule
